rc_motor_driver: RTL and testbench

//  Downstream of the RC-car command decoder. Consumes the 3-bit motion state and crash flag.

---
 rtl/rc_car_pkg.sv | 40 ++++
 rtl/rc_pwm_gen.sv | 31 +++
 rtl/rc_motor_driver.sv | 169 ++++++++++++++++
 tb/tb_rc_motor_driver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rc_car_pkg.sv
// Shared definitions for the RC-car control path: motion codes, keyboard
// command codes, motor-driver FSM states and the H-bridge pin map.
package rc_car_pkg;

  // Motion states produced by the command decoder
  localparam logic [2:0] STOP     = 3'd0;
  localparam logic [2:0] FORWARD  = 3'd1;
  localparam logic [2:0] BACKWARD = 3'd2;
  localparam logic [2:0] GO_LEFT  = 3'd3;
  localparam logic [2:0] GO_RIGHT = 3'd4;

  // ASCII command keys decoded upstream
  localparam logic [7:0] KEY_Q     = 8'h71;
  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_E     = 8'h65;
  localparam logic [7:0] KEY_R     = 8'h72;
  localparam logic [7:0] KEY_SPACE = 8'h20;

  // Motor driver sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DEAD  = 2'd3
  } drv_state_t;

  // {IN1,IN2,IN3,IN4}: left = IN1/IN2, right = IN3/IN4; 10 fwd, 01 rev
  function automatic logic [3:0] dir_to_pins(input logic [2:0] cmd);
    logic [3:0] pins;
    case (cmd)
      FORWARD:  pins = 4'b1010;
      BACKWARD: pins = 4'b0101;
      GO_LEFT:  pins = 4'b0110;
      GO_RIGHT: pins = 4'b1001;
      default:  pins = 4'b0000;
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/rc_pwm_gen.sv
// Free-running PWM: pcnt counts 0..PWM_PERIOD-1, output is the registered
// compare pcnt < duty. cut forces the output low on the next edge.
module rc_pwm_gen #(
  parameter int unsigned PWM_PERIOD = 100,
  parameter int unsigned DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cut,
  input  logic [DW-1:0] duty,
  output logic          pwm
);

  localparam logic [DW-1:0] PCNT_LAST = DW'(PWM_PERIOD - 1);

  logic [DW-1:0] pcnt;

  // Period counter, wraps after PWM_PERIOD-1
  always_ff @(posedge clk) begin
    if (rst)                    pcnt <= '0;
    else if (pcnt == PCNT_LAST) pcnt <= '0;
    else                        pcnt <= pcnt + 1'b1;
  end

  // Registered compare; duty=0 never fires, duty=PWM_PERIOD always fires
  always_ff @(posedge clk) begin
    if (rst || cut) pwm <= 1'b0;
    else            pwm <= (pcnt < duty);
  end

endmodule

// File: rtl/rc_motor_driver.sv
// Dual H-bridge driver: duty ramp, drain + dead-time on direction changes,
// immediate cut-off on a crash while forward motion is involved.
module rc_motor_driver
  import rc_car_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = 100,
  parameter int unsigned RAMP_DIV   = 1000,
  parameter int unsigned DEADTIME   = 5000,
  parameter int unsigned DUTY_FWD   = 80,
  parameter int unsigned DUTY_TURN  = 50,
  localparam int unsigned DW        = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cmd_state,
  input  logic          is_crush,
  output logic [3:0]    motor_in,
  output logic          ena,
  output logic          enb,
  output logic [DW-1:0] duty,
  output logic          busy
);

  localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned TW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
  localparam logic [TW-1:0] DEAD_LAST  = TW'(DEADTIME - 1);
  localparam logic [DW-1:0] DUTY_FWD_W = DW'(DUTY_FWD);
  localparam logic [DW-1:0] DUTY_TRN_W = DW'(DUTY_TURN);

  drv_state_t    state;
  logic [2:0]    cur_dir;
  logic [RW-1:0] ramp_cnt;
  logic [TW-1:0] dead_cnt;

  logic [2:0]    cmd_eff;
  logic          crash;
  logic [DW-1:0] target;
  logic [DW-1:0] duty_next;
  logic [RW-1:0] ramp_next;
  logic          pwm;

  // Command sanitising: unknown codes stop, forward is refused while crashed
  always_comb begin
    cmd_eff = (cmd_state > GO_RIGHT) ? STOP : cmd_state;
    if (is_crush && (cmd_eff == FORWARD)) cmd_eff = STOP;
  end

  // Cut-off only matters while the bridge may be powered (RUN/DRAIN); in DEAD
  // and IDLE duty is already 0 and the forward mask keeps it from restarting.
  always_comb begin
    crash = is_crush && ((state == RUN) || (state == DRAIN)) &&
            ((cur_dir == FORWARD) || (cmd_state == FORWARD));
  end

  // Ramp target and one saturating step toward it per ramp wrap
  always_comb begin
    target = '0;
    if (cmd_eff == cur_dir)
      target = ((cur_dir == FORWARD) || (cur_dir == BACKWARD)) ? DUTY_FWD_W : DUTY_TRN_W;
    ramp_next = (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + 1'b1;
    duty_next = duty;
    if (ramp_cnt == RAMP_LAST) begin
      if (duty < target)      duty_next = duty + 1'b1;
      else if (duty > target) duty_next = duty - 1'b1;
    end
  end

  // Sequencing FSM with registered pins, duty and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_dir  <= STOP;
      duty     <= '0;
      ramp_cnt <= '0;
      dead_cnt <= '0;
      motor_in <= '0;
      busy     <= 1'b0;
    end else if (crash) begin
      state    <= DEAD;
      cur_dir  <= STOP;
      duty     <= '0;
      ramp_cnt <= '0;
      dead_cnt <= DEAD_LAST;
      motor_in <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          duty     <= '0;
          ramp_cnt <= '0;
          busy     <= 1'b0;
          if (cmd_eff != STOP) begin
            cur_dir  <= cmd_eff;
            motor_in <= dir_to_pins(cmd_eff);
            state    <= RUN;
          end else begin
            motor_in <= '0;
          end
        end
        RUN: begin
          if ((cmd_eff == STOP) && (duty == '0)) begin
            state    <= IDLE;
            cur_dir  <= STOP;
            motor_in <= '0;
            ramp_cnt <= '0;
          end else begin
            duty     <= duty_next;
            ramp_cnt <= ramp_next;
            if ((cmd_eff != cur_dir) && (cmd_eff != STOP)) begin
              state <= DRAIN;
              busy  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cmd_eff == cur_dir) begin
            state    <= RUN;
            busy     <= 1'b0;
            duty     <= duty_next;
            ramp_cnt <= ramp_next;
          end else if (duty == '0) begin
            state    <= DEAD;
            motor_in <= '0;
            dead_cnt <= DEAD_LAST;
            ramp_cnt <= '0;
          end else begin
            duty     <= duty_next;
            ramp_cnt <= ramp_next;
          end
        end
        DEAD: begin
          duty     <= '0;
          ramp_cnt <= '0;
          if (dead_cnt == '0) begin
            busy <= 1'b0;
            if (cmd_eff == STOP) begin
              state   <= IDLE;
              cur_dir <= STOP;
            end else begin
              state    <= RUN;
              cur_dir  <= cmd_eff;
              motor_in <= dir_to_pins(cmd_eff);
            end
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rc_pwm_gen #(
    .PWM_PERIOD(PWM_PERIOD),
    .DW        (DW)
  ) u_pwm (
    .clk (clk),
    .rst (rst),
    .cut (crash),
    .duty(duty),
    .pwm (pwm)
  );

  assign ena = pwm;
  assign enb = pwm;

endmodule

// File: tb/tb_rc_motor_driver.sv
// Scoreboard bench for rc_motor_driver: stimulus pushes the expected outputs
// for each clock edge, a monitor pops and compares after every edge.
module tb_rc_motor_driver;
  import rc_car_pkg::*;

  localparam int unsigned PWM_PERIOD = 10;
  localparam int unsigned RAMP_DIV   = 2;
  localparam int unsigned DEADTIME   = 4;
  localparam int unsigned DUTY_FWD   = 8;
  localparam int unsigned DUTY_TURN  = 5;
  localparam int unsigned DW         = $clog2(PWM_PERIOD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    cmd_state = FORWARD;
  logic          is_crush = 1'b0;
  logic [3:0]    motor_in;
  logic          ena;
  logic          enb;
  logic [DW-1:0] duty;
  logic          busy;

  rc_motor_driver #(
    .PWM_PERIOD(PWM_PERIOD),
    .RAMP_DIV  (RAMP_DIV),
    .DEADTIME  (DEADTIME),
    .DUTY_FWD  (DUTY_FWD),
    .DUTY_TURN (DUTY_TURN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_state(cmd_state),
    .is_crush (is_crush),
    .motor_in (motor_in),
    .ena      (ena),
    .enb      (enb),
    .duty     (duty),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ena_mode: 0/1 exact value, 2 unchecked. win: accumulate ena/enb highs;
  // win_exp >= 0 closes the window and checks the accumulated count.
  typedef struct {
    logic [3:0] motor;
    int         duty;
    logic       busy;
    int         ena_mode;
    bit         win;
    int         win_exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   md = 0;
  int   mr = 0;
  int   acc_a = 0;
  int   acc_b = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("motor_in", int'(motor_in), int'(e.motor));
        chk("duty", int'(duty), e.duty);
        chk("busy", int'(busy), int'(e.busy));
        if (e.ena_mode != 2) begin
          chk("ena", int'(ena), e.ena_mode);
          chk("enb", int'(enb), e.ena_mode);
        end
        if (e.win) begin
          acc_a += int'(ena);
          acc_b += int'(enb);
          if (e.win_exp >= 0) begin
            chk("ena_window", acc_a, e.win_exp);
            chk("enb_window", acc_b, e.win_exp);
            acc_a = 0;
            acc_b = 0;
          end
        end
      end
    end
  end

  // Single edge with a fixed expected outcome; ramp phase restarts at 0
  task automatic step(input logic r, input logic [2:0] c, input logic cr,
                      input logic [3:0] m, input int d, input logic b, input int en);
    @(negedge clk);
    rst = r; cmd_state = c; is_crush = cr;
    sb.push_back('{motor: m, duty: d, busy: b, ena_mode: en, win: 1'b0, win_exp: -1});
    md = d;
    mr = 0;
  endtask

  // n edges of ramping: duty moves one step toward tgt on every second edge
  task automatic run_seg(input logic [2:0] c, input logic cr, input logic [3:0] m,
                         input logic b, input int tgt, input int n, input int win_exp);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = 1'b0; cmd_state = c; is_crush = cr;
      if (mr == 1) begin
        if (md < tgt)      md++;
        else if (md > tgt) md--;
      end
      mr = 1 - mr;
      sb.push_back('{motor: m, duty: md, busy: b, ena_mode: 2, win: (win_exp >= 0),
                     win_exp: ((win_exp >= 0) && (k == n - 1)) ? win_exp : -1});
    end
  endtask

  initial begin
    // Reset held with cmd=FORWARD, then idle with stop/invalid codes
    repeat (3) step(1'b1, FORWARD, 1'b0, 4'b0000, 0, 1'b0, 0);
    step(1'b0, STOP, 1'b0, 4'b0000, 0, 1'b0, 0);
    step(1'b0, 3'd5, 1'b0, 4'b0000, 0, 1'b0, 0);
    step(1'b0, 3'd7, 1'b0, 4'b0000, 0, 1'b0, 0);

    // Forward ramp to 8, then 10-cycle window of 8 high PWM cycles
    step(1'b0, FORWARD, 1'b0, 4'b1010, 0, 1'b0, 0);
    run_seg(FORWARD, 1'b0, 4'b1010, 1'b0, DUTY_FWD, 16, -1);
    run_seg(FORWARD, 1'b0, 4'b1010, 1'b0, DUTY_FWD, 10, 8);

    // Code 6 acts as STOP: ramp down with pins kept, then IDLE, never busy
    run_seg(3'd6, 1'b0, 4'b1010, 1'b0, 0, 16, -1);
    step(1'b0, 3'd6, 1'b0, 4'b0000, 0, 1'b0, 0);

    // Left pivot to 5, right requested (drain 5->2), left again resumes RUN
    step(1'b0, GO_LEFT, 1'b0, 4'b0110, 0, 1'b0, 0);
    run_seg(GO_LEFT, 1'b0, 4'b0110, 1'b0, DUTY_TURN, 10, -1);
    run_seg(GO_RIGHT, 1'b0, 4'b0110, 1'b1, 0, 6, -1);
    run_seg(GO_LEFT, 1'b0, 4'b0110, 1'b0, DUTY_TURN, 8, -1);
    run_seg(STOP, 1'b0, 4'b0110, 1'b0, 0, 10, -1);
    step(1'b0, STOP, 1'b0, 4'b0000, 0, 1'b0, 0);

    // Reversal: drain 8->0 with forward pins, 4 dead cycles, backward ramp
    step(1'b0, FORWARD, 1'b0, 4'b1010, 0, 1'b0, 0);
    run_seg(FORWARD, 1'b0, 4'b1010, 1'b0, DUTY_FWD, 16, -1);
    run_seg(BACKWARD, 1'b0, 4'b1010, 1'b1, 0, 16, -1);
    repeat (4) step(1'b0, BACKWARD, 1'b0, 4'b0000, 0, 1'b1, 0);
    step(1'b0, BACKWARD, 1'b0, 4'b0101, 0, 1'b0, 0);
    run_seg(BACKWARD, 1'b0, 4'b0101, 1'b0, DUTY_FWD, 16, -1);
    run_seg(STOP, 1'b0, 4'b0101, 1'b0, 0, 16, -1);
    step(1'b0, STOP, 1'b0, 4'b0000, 0, 1'b0, 0);

    // Crash at duty 6: immediate cut, dead time, forward refused, backward ok
    step(1'b0, FORWARD, 1'b0, 4'b1010, 0, 1'b0, 0);
    run_seg(FORWARD, 1'b0, 4'b1010, 1'b0, DUTY_FWD, 12, -1);
    step(1'b0, FORWARD, 1'b1, 4'b0000, 0, 1'b1, 0);
    repeat (3) step(1'b0, FORWARD, 1'b1, 4'b0000, 0, 1'b1, 0);
    step(1'b0, FORWARD, 1'b1, 4'b0000, 0, 1'b0, 0);
    step(1'b0, FORWARD, 1'b1, 4'b0000, 0, 1'b0, 0);
    step(1'b0, BACKWARD, 1'b1, 4'b0101, 0, 1'b0, 0);
    run_seg(BACKWARD, 1'b1, 4'b0101, 1'b0, DUTY_FWD, 4, -1);
    run_seg(STOP, 1'b0, 4'b0101, 1'b0, 0, 4, -1);
    step(1'b0, STOP, 1'b0, 4'b0000, 0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #4;
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished at %0t", $time);
    $fatal(1);
  end

endmodule
